gpio_input_filter: RTL and testbench

//  Per-pin input conditioner directly upstream of the GPIO register block.

---
 rtl/gpio_input_filter_if.sv | 32 +++
 rtl/gpio_input_filter.sv | 81 ++++++++
 tb/tb_gpio_input_filter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_input_filter_if.sv
// Pad-side and filtered-level signals between the GPIO pad ring and the input filter.
// The master drives pads and configuration; the slave is the filter itself.
interface gpio_input_filter_if #(
    parameter int N_GPIOS = 8,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 16
);
    logic [N_GPIOS-1:0] pad_i;
    logic [N_GPIOS-1:0] bypass_i;
    logic [PRESC_W-1:0] presc_i;
    logic [CNT_W-1:0]   thresh_i;
    logic [N_GPIOS-1:0] val_o;
    logic [N_GPIOS-1:0] changed_o;

    modport master (
        output pad_i,
        output bypass_i,
        output presc_i,
        output thresh_i,
        input  val_o,
        input  changed_o
    );

    modport slave (
        input  pad_i,
        input  bypass_i,
        input  presc_i,
        input  thresh_i,
        output val_o,
        output changed_o
    );
endinterface

// File: rtl/gpio_input_filter.sv
// Per-pin synchroniser and tick-based debounce feeding the GPIO block's val_i.
// Only the sample-tick prescaler is shared between pins.
module gpio_input_filter #(
    parameter int N_GPIOS     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PRESC_W     = 16
) (
    input  logic                clk,
    input  logic                rstn_i,
    gpio_input_filter_if.slave  bus
);

    logic [PRESC_W-1:0] presc_reg;
    logic               tick;

    // Comparing with >= lets a lowered presc_i take effect on the next cycle.
    assign tick = (presc_reg >= bus.presc_i);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_GPIOS; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   filt_reg;
            logic                   changed_reg;

            assign s = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pad_i[gi]};
                end
            end

            // cnt only increments while below thresh_i, so it cannot wrap.
            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    cnt_reg     <= '0;
                    filt_reg    <= 1'b0;
                    changed_reg <= 1'b0;
                end else if (bus.bypass_i[gi]) begin
                    filt_reg    <= s;
                    cnt_reg     <= '0;
                    changed_reg <= (s != filt_reg);
                end else if (s == filt_reg) begin
                    cnt_reg     <= '0;
                    changed_reg <= 1'b0;
                end else if (tick) begin
                    if (cnt_reg >= bus.thresh_i) begin
                        filt_reg    <= s;
                        cnt_reg     <= '0;
                        changed_reg <= 1'b1;
                    end else begin
                        cnt_reg     <= cnt_reg + 1'b1;
                        changed_reg <= 1'b0;
                    end
                end else begin
                    changed_reg <= 1'b0;
                end
            end

            assign bus.val_o[gi]     = filt_reg;
            assign bus.changed_o[gi] = changed_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gpio_input_filter.sv
// Bench for gpio_input_filter: directed latency/glitch/bypass/reset cases, then
// random pad activity, all compared every cycle against a behavioural model.
module tb_gpio_input_filter;
    localparam int N       = 8;
    localparam int SYNC    = 2;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 16;

    logic clk = 1'b0;
    logic rstn_i;
    always #5 clk = ~clk;

    gpio_input_filter_if #(.N_GPIOS(N), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();

    gpio_input_filter #(
        .N_GPIOS(N), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .PRESC_W(PRESC_W)
    ) dut (
        .clk   (clk),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: pad history as a delay line, a free-running sample counter and,
    // per pin, the number of ticks seen since s last differed from the level.
    logic [N-1:0] pad_hist[$];
    int           m_phase;
    logic [N-1:0] m_level;
    logic [N-1:0] m_pulse;
    int           m_ticks[N];

    task automatic model_reset();
        pad_hist.delete();
        for (int k = 0; k < SYNC; k++) pad_hist.push_back('0);
        m_phase = 0;
        m_level = '0;
        m_pulse = '0;
        for (int i = 0; i < N; i++) m_ticks[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] seen;
        bit sample;
        seen    = pad_hist[0];
        sample  = (m_phase >= int'(bus.presc_i));
        m_phase = sample ? 0 : m_phase + 1;
        m_pulse = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.bypass_i[i]) begin
                m_pulse[i] = (seen[i] != m_level[i]);
                m_level[i] = seen[i];
                m_ticks[i] = 0;
            end else if (seen[i] == m_level[i]) begin
                m_ticks[i] = 0;
            end else if (sample) begin
                if (m_ticks[i] >= int'(bus.thresh_i)) begin
                    m_level[i] = seen[i];
                    m_pulse[i] = 1'b1;
                    m_ticks[i] = 0;
                end else begin
                    m_ticks[i] = m_ticks[i] + 1;
                end
            end
        end
        void'(pad_hist.pop_front());
        pad_hist.push_back(bus.pad_i);
    endtask

    // Called just after a negedge with the next cycle's inputs applied.
    task automatic step();
        if (rstn_i) model_step();
        else        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("val_o", 32'(bus.val_o), 32'(m_level));
        check("changed_o", 32'(bus.changed_o), 32'(m_pulse));
    endtask

    task automatic async_reset_check();
        rstn_i = 1'b0;
        #1;
        check("async_val_o", 32'(bus.val_o), 32'd0);
        check("async_changed_o", 32'(bus.changed_o), 32'd0);
        model_reset();
    endtask

    initial begin
        int rise;
        int pulses;
        int high_cnt;

        rstn_i       = 1'b0;
        bus.pad_i    = '0;
        bus.bypass_i = '0;
        bus.presc_i  = '0;
        bus.thresh_i = 8'd3;
        model_reset();
        repeat (3) step();
        rstn_i = 1'b1;

        // Quiet pads after reset
        repeat (20) step();

        // Stable rising edge, presc=0, thresh=3
        bus.pad_i[0] = 1'b1;
        rise = -1; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (rise < 0 && bus.val_o[0]) rise = k;
            if (bus.changed_o[0]) pulses++;
        end
        check("t2_latency", 32'(rise), 32'd6);
        check("t2_pulses", 32'(pulses), 32'd1);

        // Glitch of 3 cycles rejected
        bus.pad_i[1] = 1'b1;
        pulses = 0; high_cnt = 0;
        for (int k = 1; k <= 23; k++) begin
            if (k == 4) bus.pad_i[1] = 1'b0;
            step();
            if (bus.changed_o[1]) pulses++;
            if (bus.val_o[1]) high_cnt++;
        end
        check("t3_pulses", 32'(pulses), 32'd0);
        check("t3_high", 32'(high_cnt), 32'd0);

        // Prescaled sampling, presc=3, thresh=1
        bus.presc_i  = 16'd3;
        bus.thresh_i = 8'd1;
        bus.pad_i[2] = 1'b1;
        rise = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (rise < 0 && bus.val_o[2]) rise = k;
        end
        check("t4_window", 32'(rise >= 6 && rise <= 9), 32'd1);

        // Bypassed pin, one-cycle pad pulse
        bus.presc_i     = '0;
        bus.thresh_i    = 8'd3;
        bus.bypass_i[3] = 1'b1;
        bus.pad_i[3]    = 1'b1;
        rise = -1; pulses = 0; high_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) bus.pad_i[3] = 1'b0;
            if (rise < 0 && bus.val_o[3]) rise = k;
            if (bus.val_o[3]) high_cnt++;
            if (bus.changed_o[3]) pulses++;
        end
        check("t5_latency", 32'(rise), 32'd3);
        check("t5_high", 32'(high_cnt), 32'd1);
        check("t5_pulses", 32'(pulses), 32'd2);
        bus.bypass_i[3] = 1'b0;

        // Long threshold with pad held through an async reset
        bus.thresh_i = 8'd200;
        bus.pad_i[4] = 1'b1;
        repeat (50) step();
        async_reset_check();
        repeat (5) step();
        rstn_i = 1'b1;
        rise = -1; pulses = 0;
        for (int k = 1; k <= 250; k++) begin
            step();
            if (rise < 0 && bus.val_o[4]) rise = k;
            if (bus.changed_o[4]) pulses++;
        end
        check("t6_latency", 32'(rise), 32'd203);
        check("t6_pulses", 32'(pulses), 32'd1);

        // Random activity with config changes mid-settle
        bus.presc_i  = 16'd1;
        bus.thresh_i = 8'd2;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) bus.pad_i[i] = ~bus.pad_i[i];
            if ($urandom_range(0, 63) == 0)  bus.bypass_i = N'($urandom);
            if ($urandom_range(0, 149) == 0) bus.presc_i  = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) bus.thresh_i = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) begin
                async_reset_check();
                step();
                rstn_i = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
